// File: rtl/shared_reg_arbiter.sv
// rtl/shared_reg_arbiter.sv - round-robin arbiter owning one shared WIDTH-bit register
module shared_reg_arbiter #(
  parameter int N           = 4,
  parameter int WIDTH       = 8,
  parameter int HOLD_CYCLES = 2,
  localparam int OW         = (N > 1) ? $clog2(N) : 1,
  localparam int CW         = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       req,
  input  logic [N*WIDTH-1:0] wdata,
  output logic [N-1:0]       gnt,
  output logic [OW-1:0]      owner,
  output logic               busy,
  output logic               last,
  output logic [WIDTH-1:0]   q,
  output logic [WIDTH-1:0]   qbar
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [N-1:0]     gnt_nxt;
  logic [OW-1:0]    owner_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [OW-1:0]    ptr, ptr_nxt;

  logic             found;
  logic [OW-1:0]    win_idx;
  logic [WIDTH-1:0] win_data;
  int               scan_idx;
  logic             arb_now;

  // Rotating priority search: first requester at or after ptr, wrapping.
  always_comb begin
    found    = 1'b0;
    win_idx  = '0;
    win_data = '0;
    scan_idx = 0;
    for (int i = 0; i < N; i++) begin
      scan_idx = int'(ptr) + i;
      if (scan_idx >= N) begin
        scan_idx = scan_idx - N;
      end
      if (!found && req[scan_idx]) begin
        found    = 1'b1;
        win_idx  = OW'(scan_idx);
        win_data = wdata[scan_idx*WIDTH +: WIDTH];
      end
    end
  end

  // Arbitrate when idle or on the final cycle of the current grant.
  assign arb_now = (state == S_IDLE) || (cnt == '0);

  // Next-state and next-register values; holding is the default.
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    owner_nxt = owner;
    q_nxt     = q;
    cnt_nxt   = cnt;
    ptr_nxt   = ptr;
    if (arb_now) begin
      if (found) begin
        state_nxt        = S_BUSY;
        gnt_nxt          = '0;
        gnt_nxt[win_idx] = 1'b1;
        owner_nxt        = win_idx;
        q_nxt            = win_data;
        cnt_nxt          = CW'(HOLD_CYCLES - 1);
        ptr_nxt          = (win_idx == OW'(N - 1)) ? '0 : win_idx + OW'(1);
      end else begin
        state_nxt = S_IDLE;
        gnt_nxt   = '0;
        owner_nxt = '0;
      end
    end else begin
      cnt_nxt = cnt - CW'(1);
    end
  end

  // State and shared register; reset aborts any grant and clears the register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      gnt   <= '0;
      owner <= '0;
      q     <= '0;
      cnt   <= '0;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      owner <= owner_nxt;
      q     <= q_nxt;
      cnt   <= cnt_nxt;
      ptr   <= ptr_nxt;
    end
  end

  assign busy = |gnt;
  assign last = busy && (cnt == '0);
  assign qbar = ~q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// tb/tb_shared_reg_arbiter.sv - directed and soak checks for shared_reg_arbiter
module tb_shared_reg_arbiter;

  localparam int N     = 4;
  localparam int WIDTH = 8;
  localparam int HOLD  = 2;

  logic             clk;
  logic             rst;
  logic [N-1:0]     req;
  logic [N*WIDTH-1:0] wdata;
  logic [N-1:0]     gnt;
  logic [1:0]       owner;
  logic             busy;
  logic             last;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;

  int errors = 0;
  int checks = 0;

  shared_reg_arbiter #(.N(N), .WIDTH(WIDTH), .HOLD_CYCLES(HOLD)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .wdata (wdata),
    .gnt   (gnt),
    .owner (owner),
    .busy  (busy),
    .last  (last),
    .q     (q),
    .qbar  (qbar)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    req   = 4'b1111;
    wdata = $urandom;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (gnt !== 4'b0000 || busy !== 1'b0 || last !== 1'b0 || owner !== 2'd0) begin
        errors++;
        $display("FAIL reset_ctl cyc%0d: gnt=%b busy=%b last=%b owner=%0d, need 0000/0/0/0", c, gnt, busy, last, owner);
      end
      checks++;
      if (q !== 8'h00 || qbar !== 8'hFF) begin
        errors++;
        $display("FAIL reset_q cyc%0d: q=%h qbar=%h, need 00/ff", c, q, qbar);
      end
    end
    rst = 1'b0;
    req = 4'b0000;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (gnt !== 4'b0000 || busy !== 1'b0 || q !== 8'h00 || qbar !== 8'hFF) begin
        errors++;
        $display("FAIL reset_release cyc%0d: gnt=%b busy=%b q=%h qbar=%h, need idle", c, gnt, busy, q, qbar);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    req   = 4'b0100;
    wdata = {8'h00, 8'hA5, 8'h00, 8'h00};
    tick();
    checks++;
    if (gnt !== 4'b0100 || owner !== 2'd2 || busy !== 1'b1 || last !== 1'b0) begin
      errors++;
      $display("FAIL single_c1: gnt=%b owner=%0d busy=%b last=%b, need 0100/2/1/0", gnt, owner, busy, last);
    end
    checks++;
    if (q !== 8'hA5 || qbar !== 8'h5A) begin
      errors++;
      $display("FAIL single_q: q=%h qbar=%h, need a5/5a", q, qbar);
    end
    tick();
    checks++;
    if (gnt !== 4'b0100 || last !== 1'b1) begin
      errors++;
      $display("FAIL single_c2: gnt=%b last=%b, need 0100/1", gnt, last);
    end
    req = 4'b0000;
    tick();
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || owner !== 2'd0 || q !== 8'hA5) begin
      errors++;
      $display("FAIL single_drop: gnt=%b busy=%b owner=%0d q=%h, need 0000/0/0/a5", gnt, busy, owner, q);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0]     eg;
    logic [WIDTH-1:0] eq;
    do_reset();
    req   = 4'b1111;
    wdata = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int g = 0; g < 6; g++) begin
      eg = 4'b0001 << (g % 4);
      eq = 8'h10 + 8'(g % 4);
      for (int c = 0; c < HOLD; c++) begin
        tick();
        checks++;
        if (gnt !== eg || owner !== 2'(g % 4) || q !== eq || last !== (c == HOLD - 1)) begin
          errors++;
          $display("FAIL rr g%0d c%0d: gnt=%b owner=%0d q=%h last=%b, need %b/%0d/%h/%b",
                   g, c, gnt, owner, q, last, eg, g % 4, eq, c == HOLD - 1);
        end
      end
    end
    req = 4'b0000;
    tick();
    checks++;
    if (gnt !== 4'b0000 || q !== 8'h11) begin
      errors++;
      $display("FAIL rr_end: gnt=%b q=%h, need 0000/11", gnt, q);
    end
  endtask

  task automatic test_fairness();
    logic [1:0] exp_o;
    do_reset();
    req   = 4'b1001;
    wdata = {8'h33, 8'h22, 8'h11, 8'h00};
    for (int g = 0; g < 4; g++) begin
      exp_o = (g % 2 == 0) ? 2'd0 : 2'd3;
      for (int c = 0; c < HOLD; c++) begin
        tick();
        checks++;
        if (owner !== exp_o || gnt !== (4'b0001 << exp_o) || q !== ((exp_o == 2'd0) ? 8'h00 : 8'h33)) begin
          errors++;
          $display("FAIL fair g%0d c%0d: owner=%0d gnt=%b q=%h, need owner %0d", g, c, owner, gnt, q, exp_o);
        end
      end
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_mid_grant();
    do_reset();
    req   = 4'b0010;
    wdata = {8'h00, 8'h00, 8'h3C, 8'h00};
    tick();
    checks++;
    if (gnt !== 4'b0010 || q !== 8'h3C) begin
      errors++;
      $display("FAIL mid_start: gnt=%b q=%h, need 0010/3c", gnt, q);
    end
    req   = 4'b0000;
    wdata = {8'h00, 8'h00, 8'hFF, 8'h00};
    tick();
    checks++;
    if (gnt !== 4'b0010 || q !== 8'h3C || last !== 1'b1) begin
      errors++;
      $display("FAIL mid_hold: gnt=%b q=%h last=%b, need 0010/3c/1", gnt, q, last);
    end
    tick();
    checks++;
    if (gnt !== 4'b0000 || q !== 8'h3C) begin
      errors++;
      $display("FAIL mid_end: gnt=%b q=%h, need 0000/3c", gnt, q);
    end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req   = 4'b0100;
    wdata = {8'h00, 8'h77, 8'h00, 8'h00};
    tick();
    checks++;
    if (gnt !== 4'b0100 || q !== 8'h77) begin
      errors++;
      $display("FAIL rmid_start: gnt=%b q=%h, need 0100/77", gnt, q);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || q !== 8'h00 || qbar !== 8'hFF) begin
      errors++;
      $display("FAIL rmid_abort: gnt=%b busy=%b q=%h qbar=%h, need 0000/0/00/ff", gnt, busy, q, qbar);
    end
    rst   = 1'b0;
    req   = 4'b1010;
    wdata = {8'hD3, 8'h00, 8'hB1, 8'h00};
    tick();
    checks++;
    if (gnt !== 4'b0010 || owner !== 2'd1 || q !== 8'hB1) begin
      errors++;
      $display("FAIL rmid_ptr: gnt=%b owner=%0d q=%h, need 0010/1/b1", gnt, owner, q);
    end
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_soak();
    logic [N-1:0]     m_gnt;
    logic [1:0]       m_owner;
    logic [WIDTH-1:0] m_q;
    int               m_cnt;
    int               m_ptr;
    int               run_len;
    int               k;
    bit               hit;
    do_reset();
    m_gnt   = '0;
    m_owner = '0;
    m_q     = '0;
    m_cnt   = 0;
    m_ptr   = 0;
    run_len = 0;
    for (int c = 0; c < 1000; c++) begin
      req   = 4'($urandom_range(0, 15));
      wdata = $urandom;
      if (m_gnt == '0 || m_cnt == 0) begin
        hit = 1'b0;
        for (int j = 0; j < N; j++) begin
          k = (m_ptr + j) % N;
          if (!hit && req[k]) begin
            hit     = 1'b1;
            m_gnt   = 4'b0001 << k;
            m_owner = 2'(k);
            m_q     = wdata[k*WIDTH +: WIDTH];
            m_cnt   = HOLD - 1;
            m_ptr   = (k + 1) % N;
          end
        end
        if (!hit) begin
          m_gnt   = '0;
          m_owner = '0;
        end
      end else begin
        m_cnt = m_cnt - 1;
      end
      tick();
      checks++;
      if (gnt !== m_gnt || owner !== m_owner || q !== m_q || qbar !== ~m_q ||
          busy !== (m_gnt != '0) || last !== (m_gnt != '0 && m_cnt == 0)) begin
        errors++;
        $display("FAIL soak c%0d: gnt=%b owner=%0d q=%h last=%b, need %b/%0d/%h/%b",
                 c, gnt, owner, q, last, m_gnt, m_owner, m_q, (m_gnt != '0 && m_cnt == 0));
      end
      if (busy) run_len++;
      if (last) begin
        checks++;
        if (run_len !== HOLD) begin
          errors++;
          $display("FAIL soak_len c%0d: grant length=%0d, need %0d", c, run_len, HOLD);
        end
        run_len = 0;
      end
    end
    req = '0;
  endtask

  initial begin
    rst   = 1'b1;
    req   = '0;
    wdata = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_fairness();
    test_mid_grant();
    test_reset_mid_grant();
    test_soak();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
